mixer_ser_rx: RTL and testbench
===============================

# mixer_ser_rx

Serial control-word receiver on the analog side of the mixer control link. It samples a 3-wire serial stream (ser_clk, ser_data, ser_le) with the system clock and decodes 8-bit frames into the mixer control lines pd, ota and buff. It also provides a CPU read port so firmware can read back the applied settings and the frame-error status.

## Interface
- Single clock `clk`. Synchronous, active-high reset `rst`. Both are fixed.
- WORD_W, 8: frame length in bits. Bits [7:6] are the register address and bits [5:0] are data.
- SYNC_STAGES, 2: synchronizer depth on each serial input.
- DATA_W, 32: CPU read data width.
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ser_clk  in  1  serial bit clock; asynchronous to clk.
- ser_data  in  1  serial data, MSB first; valid on the ser_clk rising edge.
- ser_le  in  1  latch enable; its rising edge ends a frame.
- valid  in  1  CPU read request.
- address  in  2  CPU read address.
- rdata  out  DATA_W  CPU read data.
- ready  out  1  CPU read acknowledge.
- pd  out  1  mixer power-down.
- ota  out  1  OTA enable.
- buff  out  2  buffer control.
- update  out  1  one-cycle pulse when a frame has been applied.
- frame_err  out  1  one-cycle pulse when a frame is rejected.

## Operation
- Synchronization:
  - Each serial input passes through a SYNC_STAGES flop chain.
  - Edges are detected by comparing the synchronized value with its value one cycle earlier.
- State machine, IDLE/SHIFT:
  - IDLE: bit count is 0. A ser_clk rise shifts ser_data into shreg[0] (shreg shifts left), sets count to 1 and moves to SHIFT.
  - SHIFT: each ser_clk rise shifts one bit and increments count. Count saturates at WORD_W+1.
  - An ser_le rise in either state ends the frame and returns to IDLE with count 0.
- Frame end:
  - A frame is valid when count == WORD_W and shreg[7:6] != 3.
  - Address 0: pd <= shreg[0]. Address 1: ota <= shreg[0]. Address 2: buff <= shreg[1:0].
  - A valid frame pulses update. Any other frame (count != WORD_W, or address 3) pulses frame_err, changes no output, and sets err_sticky.
  - An ser_le rise in IDLE with count 0 is an empty frame and is treated as an error.
- Input priority:
  - ser_clk rise and ser_le rise detected in the same cycle: ser_le wins and the clock edge is discarded.
  - ser_clk edges while ser_le is synchronized high are ignored.
- CPU read:
  - When valid is high, rdata and ready are registered on the next edge.
  - Address 0 returns {0, pd}. Address 1 returns {0, ota}. Address 2 returns {0, buff}. Address 3 returns {0, err_sticky, last_count[3:0]}.
  - A read of address 3 clears err_sticky. If an error occurs in the same cycle, the set wins.
  - ready is 0 when valid is low. rdata holds its last value.
- Reset values: pd, ota, buff, update, frame_err, ready, rdata, shreg, count, err_sticky and last_count are all 0. State is IDLE and the synchronizer flops are 0.
- Reset mid-frame discards the partial frame. The first frame after reset must start with a full 8 clocks.

## Timing
- ser_clk high and low times must each be at least SYNC_STAGES+1 clk periods. ser_data setup and hold around the ser_clk rise must be at least the same.
- Edge detect timing: with SYNC_STAGES=2, an input first sampled high at clk edge k is detected in the cycle after edge k+2.
- Output latency:
  - The register writes at edge k+3, and pd/ota/buff change then.
  - update or frame_err is high for exactly the cycle following edge k+3.
- Back-to-back frames need ser_le low for at least SYNC_STAGES+1 cycles between them.
- CPU read latency is 1 cycle. A continuous valid gives a continuous ready.

## Structure
- Shared package mixer_pkg holds:
  - the address constants MIXER_PD=0, MIXER_OTA=1, MIXER_BUFF=2, MIXER_STAT=3;
  - the MIXER_ADDR_W=2 width define;
  - the frame field offsets;
  - the IDLE/SHIFT state encodings.
- Sub-module `ser_sync_edge`: parameterized synchronizer plus rising-edge detector, instantiated once for each serial input.

## Test plan
- After reset, frame 0x01 (addr 0, data 1) with 8 clocks, then le -> pd=1 at edge k+3, one update pulse, ota=0, buff=0.
- Frame 0x83 (addr 2) -> buff=2'b11. Then frame 0x40 -> ota=0, with pd and buff unchanged.
- Frame of 7 bits, then a frame of 9 bits, then le alone -> three frame_err pulses and no output change. A read of address 3 returns err_sticky=1; a second read returns 0.
- Frame 0xC1 (addr 3) -> frame_err and no change. A read of address 3 gives last_count=8.
- ser_clk rise and ser_le rise in the same sampled cycle after 7 bits -> the edge is discarded and frame_err is raised.
- rst asserted after 4 bits, then a full frame 0x41 -> ota=1 with no spurious update. CPU reads of addresses 0-2 during the frame have ready 1 cycle after valid.

Source files
------------

// File: rtl/mixer_pkg.sv
// Shared constants for the mixer control link: register addresses, frame
// field offsets and the receiver state encoding.
package mixer_pkg;

   localparam int MIXER_ADDR_W = 2;

   localparam logic [MIXER_ADDR_W-1:0] MIXER_PD   = 2'd0;
   localparam logic [MIXER_ADDR_W-1:0] MIXER_OTA  = 2'd1;
   localparam logic [MIXER_ADDR_W-1:0] MIXER_BUFF = 2'd2;
   localparam logic [MIXER_ADDR_W-1:0] MIXER_STAT = 2'd3;

   localparam int FRAME_ADDR_LSB = 6;
   localparam int FRAME_DATA_LSB = 0;
   localparam int FRAME_BUFF_W   = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } rxState_e;

endpackage

// File: rtl/ser_sync_edge.sv
// Synchronizer chain for one asynchronous serial input, with a registered
// rising-edge pulse derived from the synchronized level.
module ser_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din_i,
   output logic level_o,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic              rise_q;

   // The edge pulse is registered so it lands one cycle after the level settles.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q[0] <= din_i;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_q[STAGES-1];
         rise_q <= sync_q[STAGES-1] & ~prev_q;
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = rise_q;

endmodule

// File: rtl/mixer_ser_rx.sv
// Serial control-word receiver: decodes 8-bit frames from a 3-wire link into
// the mixer control lines and offers a CPU read-back port.
module mixer_ser_rx
   import mixer_pkg::*;
#(
   parameter int WORD_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DATA_W      = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ser_clk,
   input  logic                    ser_data,
   input  logic                    ser_le,
   input  logic                    valid,
   input  logic [MIXER_ADDR_W-1:0] address,
   output logic [DATA_W-1:0]       rdata,
   output logic                    ready,
   output logic                    pd,
   output logic                    ota,
   output logic [1:0]              buff,
   output logic                    update,
   output logic                    frame_err
);

   localparam int CNT_W = $clog2(WORD_W + 2);

   logic clkRise, leRise, leLevel, dataLevel;
   logic unusedClkLevel, unusedDataRise;

   ser_sync_edge #(.STAGES(SYNC_STAGES)) uClkSync (
      .clk     (clk),
      .rst     (rst),
      .din_i   (ser_clk),
      .level_o (unusedClkLevel),
      .rise_o  (clkRise)
   );

   ser_sync_edge #(.STAGES(SYNC_STAGES)) uDataSync (
      .clk     (clk),
      .rst     (rst),
      .din_i   (ser_data),
      .level_o (dataLevel),
      .rise_o  (unusedDataRise)
   );

   ser_sync_edge #(.STAGES(SYNC_STAGES)) uLeSync (
      .clk     (clk),
      .rst     (rst),
      .din_i   (ser_le),
      .level_o (leLevel),
      .rise_o  (leRise)
   );

   rxState_e                state_q, state_d;
   logic [WORD_W-1:0]       shreg_q, shreg_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [CNT_W-1:0]        lastCount_q;
   logic                    pd_q, ota_q, update_q, frameErr_q, errSticky_q, ready_q;
   logic [1:0]              buff_q;
   logic [DATA_W-1:0]       rdata_q;

   logic                    bitRise;
   logic                    frameOk, frameBad;
   logic [MIXER_ADDR_W-1:0] frameAddr;
   logic                    statRead;
   logic [DATA_W-1:0]       readData;
   logic [3:0]              lastCountNib;

   // A latch-enable rise always wins; clock edges are dropped while it is high.
   assign bitRise   = clkRise & ~leLevel & ~leRise;
   assign frameAddr = shreg_q[FRAME_ADDR_LSB +: MIXER_ADDR_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      count_d = count_q;
      if (leRise) begin
         state_d = IDLE;
         count_d = '0;
      end else if (bitRise) begin
         state_d = SHIFT;
         shreg_d = {shreg_q[WORD_W-2:0], dataLevel};
         if (state_q == IDLE) begin
            count_d = CNT_W'(1);
         end else if (count_q != CNT_W'(WORD_W + 1)) begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      frameOk  = 1'b0;
      frameBad = 1'b0;
      if (leRise) begin
         frameOk  = (count_q == CNT_W'(WORD_W)) && (frameAddr != MIXER_STAT);
         frameBad = ~frameOk;
      end
   end

   // Applies accepted frames and tracks the error status seen by firmware.
   always_ff @(posedge clk) begin
      if (rst) begin
         pd_q        <= 1'b0;
         ota_q       <= 1'b0;
         buff_q      <= '0;
         update_q    <= 1'b0;
         frameErr_q  <= 1'b0;
         errSticky_q <= 1'b0;
         lastCount_q <= '0;
      end else begin
         update_q   <= frameOk;
         frameErr_q <= frameBad;
         if (leRise) begin
            lastCount_q <= count_q;
         end
         if (frameOk) begin
            case (frameAddr)
               MIXER_PD:   pd_q   <= shreg_q[FRAME_DATA_LSB];
               MIXER_OTA:  ota_q  <= shreg_q[FRAME_DATA_LSB];
               MIXER_BUFF: buff_q <= shreg_q[FRAME_DATA_LSB +: FRAME_BUFF_W];
               default:    ;
            endcase
         end
         if (frameBad) begin
            errSticky_q <= 1'b1;
         end else if (statRead) begin
            errSticky_q <= 1'b0;
         end
      end
   end

   assign statRead     = valid && (address == MIXER_STAT);
   assign lastCountNib = 4'(lastCount_q);

   always_comb begin
      readData = '0;
      case (address)
         MIXER_PD:   readData[0]   = pd_q;
         MIXER_OTA:  readData[0]   = ota_q;
         MIXER_BUFF: readData[1:0] = buff_q;
         default:    readData[4:0] = {errSticky_q, lastCountNib};
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         ready_q <= valid;
         if (valid) begin
            rdata_q <= readData;
         end
      end
   end

   assign pd        = pd_q;
   assign ota       = ota_q;
   assign buff      = buff_q;
   assign update    = update_q;
   assign frame_err = frameErr_q;
   assign ready     = ready_q;
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_mixer_ser_rx.sv
// Directed self-checking bench for mixer_ser_rx: frames are bit-banged on the
// serial pins and outputs/pulse counts are compared with hand-computed values.
module tb_mixer_ser_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ser_clk = 1'b0;
   logic        ser_data = 1'b0;
   logic        ser_le = 1'b0;
   logic        valid = 1'b0;
   logic [1:0]  address = 2'd0;
   logic [31:0] rdata;
   logic        ready;
   logic        pd;
   logic        ota;
   logic [1:0]  buff;
   logic        update;
   logic        frame_err;

   int assertCount = 0;
   int failCount   = 0;
   int updCnt      = 0;
   int errCnt      = 0;
   int updBase     = 0;
   int errBase     = 0;

   mixer_ser_rx #(
      .WORD_W      (8),
      .SYNC_STAGES (2),
      .DATA_W      (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ser_clk   (ser_clk),
      .ser_data  (ser_data),
      .ser_le    (ser_le),
      .valid     (valid),
      .address   (address),
      .rdata     (rdata),
      .ready     (ready),
      .pd        (pd),
      .ota       (ota),
      .buff      (buff),
      .update    (update),
      .frame_err (frame_err)
   );

   // Free-running system clock, 10 time units per period.
   always #5 clk = ~clk;

   // Counts every update and frame_err pulse so frames can be checked by delta.
   always @(posedge clk) begin
      if (!rst) begin
         if (update)    updCnt++;
         if (frame_err) errCnt++;
      end
   end

   // Hard time limit so a stuck run still reports and ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sendBit(input logic b);
      ser_data = b;
      waitCycles(4);
      ser_clk = 1'b1;
      waitCycles(4);
      ser_clk = 1'b0;
   endtask

   task automatic applyStimulus(input logic [15:0] value, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         sendBit(value[i]);
      end
   endtask

   task automatic pulseLe();
      ser_le = 1'b1;
      waitCycles(4);
      ser_le = 1'b0;
      waitCycles(6);
   endtask

   task automatic markCounts();
      updBase = updCnt;
      errBase = errCnt;
   endtask

   task automatic cpuRead(input string tag, input logic [1:0] addr, input logic [31:0] expected);
      valid   = 1'b1;
      address = addr;
      checkOutput({tag, "_ready_pre"}, {31'd0, ready}, 32'd0);
      @(negedge clk);
      checkOutput({tag, "_ready"}, {31'd0, ready}, 32'd1);
      checkOutput({tag, "_rdata"}, rdata, expected);
      valid = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_ready_post"}, {31'd0, ready}, 32'd0);
   endtask

   initial begin
      $display("[TB] start");
      waitCycles(4);
      checkOutput("rst_pd", {31'd0, pd}, 32'd0);
      checkOutput("rst_ota", {31'd0, ota}, 32'd0);
      checkOutput("rst_buff", {30'd0, buff}, 32'd0);
      checkOutput("rst_update", {31'd0, update}, 32'd0);
      checkOutput("rst_ferr", {31'd0, frame_err}, 32'd0);
      checkOutput("rst_ready", {31'd0, ready}, 32'd0);
      checkOutput("rst_rdata", rdata, 32'd0);
      rst = 1'b0;
      waitCycles(4);

      // Frame 0x01 with exact latency check around the latch-enable rise.
      markCounts();
      applyStimulus(16'h0001, 8);
      waitCycles(2);
      ser_le = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("f01_pd_k2", {31'd0, pd}, 32'd0);
      checkOutput("f01_upd_k2", {31'd0, update}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("f01_pd_k3", {31'd0, pd}, 32'd1);
      checkOutput("f01_upd_k3", {31'd0, update}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput("f01_upd_k4", {31'd0, update}, 32'd0);
      @(negedge clk);
      ser_le = 1'b0;
      waitCycles(6);
      checkOutput("f01_ota", {31'd0, ota}, 32'd0);
      checkOutput("f01_buff", {30'd0, buff}, 32'd0);
      checkOutput("f01_updcnt", 32'(updCnt - updBase), 32'd1);
      checkOutput("f01_errcnt", 32'(errCnt - errBase), 32'd0);

      // Frame 0x83: buffer control gets 2'b11.
      markCounts();
      applyStimulus(16'h0083, 8);
      pulseLe();
      checkOutput("f83_buff", {30'd0, buff}, 32'd3);
      checkOutput("f83_updcnt", 32'(updCnt - updBase), 32'd1);

      // Frame 0x40: OTA written low, other lines untouched.
      applyStimulus(16'h0040, 8);
      pulseLe();
      checkOutput("f40_ota", {31'd0, ota}, 32'd0);
      checkOutput("f40_pd", {31'd0, pd}, 32'd1);
      checkOutput("f40_buff", {30'd0, buff}, 32'd3);

      // Short frame, long frame and an empty latch: three rejections.
      markCounts();
      applyStimulus(16'h0020, 7);
      pulseLe();
      applyStimulus(16'h0141, 9);
      pulseLe();
      pulseLe();
      checkOutput("bad_errcnt", 32'(errCnt - errBase), 32'd3);
      checkOutput("bad_updcnt", 32'(updCnt - updBase), 32'd0);
      checkOutput("bad_pd", {31'd0, pd}, 32'd1);
      checkOutput("bad_ota", {31'd0, ota}, 32'd0);
      checkOutput("bad_buff", {30'd0, buff}, 32'd3);
      cpuRead("stat_rd1", 2'd3, 32'h10);
      cpuRead("stat_rd2", 2'd3, 32'h00);

      // Frame 0xC1 addresses the status slot and is rejected.
      markCounts();
      applyStimulus(16'h00C1, 8);
      pulseLe();
      checkOutput("fc1_errcnt", 32'(errCnt - errBase), 32'd1);
      checkOutput("fc1_updcnt", 32'(updCnt - updBase), 32'd0);
      checkOutput("fc1_pd", {31'd0, pd}, 32'd1);
      cpuRead("fc1_stat", 2'd3, 32'h18);

      // Eighth clock edge coincides with the latch rise: edge must be dropped.
      markCounts();
      applyStimulus(16'h0020, 7);
      ser_data = 1'b1;
      waitCycles(4);
      ser_clk = 1'b1;
      ser_le  = 1'b1;
      waitCycles(4);
      ser_clk = 1'b0;
      ser_le  = 1'b0;
      waitCycles(6);
      checkOutput("tie_errcnt", 32'(errCnt - errBase), 32'd1);
      checkOutput("tie_updcnt", 32'(updCnt - updBase), 32'd0);
      checkOutput("tie_ota", {31'd0, ota}, 32'd0);
      cpuRead("tie_stat", 2'd3, 32'h17);

      // Reset in the middle of a frame, then a clean 0x41 with reads in between.
      applyStimulus(16'h0004, 4);
      rst = 1'b1;
      waitCycles(3);
      rst = 1'b0;
      waitCycles(2);
      checkOutput("mrst_pd", {31'd0, pd}, 32'd0);
      checkOutput("mrst_buff", {30'd0, buff}, 32'd0);
      markCounts();
      applyStimulus(16'h0002, 3);
      cpuRead("mid_rd0", 2'd0, 32'd0);
      applyStimulus(16'h0000, 2);
      cpuRead("mid_rd1", 2'd1, 32'd0);
      applyStimulus(16'h0001, 3);
      cpuRead("mid_rd2", 2'd2, 32'd0);
      pulseLe();
      checkOutput("f41_ota", {31'd0, ota}, 32'd1);
      checkOutput("f41_updcnt", 32'(updCnt - updBase), 32'd1);
      checkOutput("f41_errcnt", 32'(errCnt - errBase), 32'd0);
      cpuRead("f41_rd1", 2'd1, 32'd1);
      cpuRead("f41_stat", 2'd3, 32'h08);

      // Continuous valid keeps ready asserted every cycle.
      valid   = 1'b1;
      address = 2'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("burst_ready", {31'd0, ready}, 32'd1);
         checkOutput("burst_rdata", rdata, 32'd1);
      end
      valid = 1'b0;
      @(negedge clk);
      checkOutput("burst_idle", {31'd0, ready}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
